pipe_hazard_sequencer: RTL and testbench



---
 rtl/pipe_hazard_sequencer.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer: per-stage enable/bubble/flush sequencing for the 5-stage 16-bit CPU.
// Optional stall/flush performance counters are built when PIPE_PERF_EN is defined.
module pipe_hazard_sequencer #(
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_redirect,
   input  logic              mem_access,
   input  logic              mem_ready,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_we,
   output logic              idex_bubble,
   output logic              exmem_we,
   output logic              mem_req,
   output logic              mem_err,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN = 2'b00, LDSTALL = 2'b01, MEMWAIT = 2'b10, ERR = 2'b11} state_t;

   state_t         cur, nxt;
   logic [WCW-1:0] wait_cnt;
   logic           rs_used, hazard;

   assign rs_used = (id_opcode <= 4'd9) | (id_opcode >= 4'd14);
   assign hazard  = ex_valid & ex_is_load & (ex_rd != '0) &
                    ((rs_used & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));
   assign state   = cur;

   // Stage controls and next state; memory stall beats redirect beats load-use, reset forces NOPs.
   always_comb begin
      nxt         = cur;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      mem_req     = 1'b0;
      case (cur)
         RUN, LDSTALL: begin
            nxt     = RUN;
            mem_req = mem_access;
            if (mem_access && !mem_ready) begin
               {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
               nxt = MEMWAIT;
            end else if (ex_redirect) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (hazard && cur == RUN) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
               nxt         = LDSTALL;
            end
         end
         MEMWAIT: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               nxt         = RUN;
               ifid_flush  = ex_redirect;
               idex_bubble = ex_redirect;
            end else begin
               {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
               nxt = (wait_cnt >= TMO) ? ERR : MEMWAIT;
            end
         end
         default: begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            nxt = ERR;
         end
      endcase
      if (!rst_n) begin
         {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
         mem_req     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   // State, memory-wait counter (1 on entry) and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         cur      <= nxt;
         wait_cnt <= (nxt != MEMWAIT) ? '0 : (cur == MEMWAIT) ? wait_cnt + 1'b1 : WCW'(1);
         if (nxt == ERR) mem_err <= 1'b1;
      end
   end

`ifdef PIPE_PERF_EN
   // Saturating counts of stalled-PC cycles and IF/ID flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_we && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// tb_pipe_hazard_sequencer: directed vector table plus timeout and reset sequences.
module tb_pipe_hazard_sequencer;

   // ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_req, mem_err}
   localparam logic [7:0] NORM = 8'b11010100;
   localparam logic [7:0] LU   = 8'b00011100;
   localparam logic [7:0] LUM  = 8'b00011110;
   localparam logic [7:0] RDR  = 8'b11111100;
   localparam logic [7:0] FRZ  = 8'b00000010;
   localparam logic [7:0] MOK  = 8'b11010110;
   localparam logic [7:0] MRDR = 8'b11111110;
   localparam logic [7:0] ERRV = 8'b00000001;
   localparam logic [7:0] RST  = 8'b00101000;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  id_opcode = '0, id_rs = '0, id_rt = '0, ex_rd = '0;
   logic        id_uses_rt = 0, ex_valid = 0, ex_is_load = 0, ex_redirect = 0;
   logic        mem_access = 0, mem_ready = 0;
   logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_req, mem_err;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;
   int          passed = 0, total = 0, m_stall = 0, m_flush = 0;

   typedef struct {
      logic [3:0] op, rs, rt;
      logic       ur, ev, el;
      logic [3:0] rd;
      logic       rdr, ma, mr;
      logic [7:0] ctl;
      logic [1:0] st;
   } vec_t;

   vec_t v[$];

   pipe_hazard_sequencer dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_redirect(ex_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
      .idex_bubble(idex_bubble), .exmem_we(exmem_we), .mem_req(mem_req), .mem_err(mem_err),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int op, int rs, int rt, int ur, int ev, int el, int rd,
                               int rdr, int ma, int mr, logic [7:0] ctl, int st);
      vec_t r;
      r.op = 4'(op); r.rs = 4'(rs); r.rt = 4'(rt);
      r.ur = 1'(ur); r.ev = 1'(ev); r.el = 1'(el); r.rd = 4'(rd);
      r.rdr = 1'(rdr); r.ma = 1'(ma); r.mr = 1'(mr);
      r.ctl = ctl; r.st = 2'(st);
      return r;
   endfunction

   task automatic drive(input vec_t x);
      id_opcode = x.op; id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.ur;
      ex_valid = x.ev; ex_is_load = x.el; ex_rd = x.rd;
      ex_redirect = x.rdr; mem_access = x.ma; mem_ready = x.mr;
   endtask

   task automatic chk(input string nm, input logic [7:0] ctl, input logic [1:0] st);
      logic [7:0] act;
      act = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_req, mem_err};
      total++;
      if (act === ctl && state === st) passed++;
      else $display("FAIL %s: ctl=%b state=%b, required ctl=%b state=%b", nm, act, state, ctl, st);
      if (rst_n) begin
         if (!ctl[7]) m_stall++;
         if (ctl[5]) m_flush++;
      end
   endtask

   initial begin
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,3,0,0,1,1,3, 0,0,0, LU,  0));
      v.push_back(mk( 0,3,0,0,1,1,3, 0,0,0, NORM,1));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,0,0,0,1,1,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,1,5,0,1,1,5, 0,0,0, NORM,0));
      v.push_back(mk( 0,1,5,1,1,1,5, 0,0,0, LU,  0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,1));
      v.push_back(mk(10,4,0,0,1,1,4, 0,0,0, NORM,0));
      v.push_back(mk(14,4,0,0,1,1,4, 0,0,0, LU,  0));
      v.push_back(mk( 0,0,0,0,0,0,0, 1,0,0, RDR, 1));
      v.push_back(mk( 1,2,0,0,1,1,2, 1,0,0, RDR, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,3,0,0,0,1,3, 0,0,0, NORM,0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,1, MOK, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,0, FRZ, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,0, FRZ, 2));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,0, FRZ, 2));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,1, MOK, 2));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,0,0,0,0,0,0, 1,1,0, FRZ, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 1,1,1, MRDR,2));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));
      v.push_back(mk( 0,3,0,0,1,1,3, 0,1,0, FRZ, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,1, MOK, 2));
      v.push_back(mk( 0,3,0,0,1,1,3, 0,1,1, LUM, 0));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,0, FRZ, 1));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,1,1, MOK, 2));
      v.push_back(mk( 0,0,0,0,0,0,0, 0,0,0, NORM,0));

      @(negedge clk); #1;
      chk("reset", RST, 2'b00);
      rst_n = 1'b1;

      foreach (v[i]) begin
         @(negedge clk);
         drive(v[i]);
         #1 chk($sformatf("vec%0d", i), v[i].ctl, v[i].st);
      end

      // timeout: one RUN freeze, fifteen MEMWAIT cycles, then sticky ERR
      @(negedge clk);
      drive(mk(0,0,0,0,0,0,0, 0,1,0, FRZ,0));
      #1 chk("to_start", FRZ, 2'b00);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk); #1;
         chk($sformatf("to_wait%0d", i), FRZ, 2'b10);
      end
      @(negedge clk); #1;
      chk("to_err", ERRV, 2'b11);
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("err_hold%0d", i), ERRV, 2'b11);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("err_reset", RST, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk(0,0,0,0,0,0,0, 0,0,0, NORM,0));
      #1 chk("err_release", NORM, 2'b00);

      // asynchronous reset between edges while in MEMWAIT
      @(negedge clk);
      drive(mk(0,0,0,0,0,0,0, 0,1,0, FRZ,0));
      #1 chk("ar_start", FRZ, 2'b00);
      @(negedge clk); #1;
      chk("ar_wait", FRZ, 2'b10);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1 chk("ar_reset", RST, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk(0,0,0,0,0,0,0, 0,0,0, NORM,0));
      #1 chk("ar_release", NORM, 2'b00);

      @(negedge clk);
`ifdef PIPE_PERF_EN
      total++;
      if (stall_cnt == 16'(m_stall)) passed++;
      else $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, m_stall);
      total++;
      if (flush_cnt == 16'(m_flush)) passed++;
      else $display("FAIL flush_cnt: got %0d, required %0d", flush_cnt, m_flush);
`else
      total++;
      if (stall_cnt == 16'd0) passed++;
      else $display("FAIL stall_cnt tie: got %0d, required 0", stall_cnt);
      total++;
      if (flush_cnt == 16'd0) passed++;
      else $display("FAIL flush_cnt tie: got %0d, required 0", flush_cnt);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
